// File: rtl/uart_mmio_periph.sv
// UART peripheral with a three-register memory-mapped interface.
// TX_ADDR holds the byte to send, RX_ADDR returns the last received byte,
// CTRL_ADDR reads status {framing_err, overrun, rx_valid, tx_busy}; a write
// to it starts a transmit (bit 0) and clears the error flags (bit 1).
// TX and RX run independently for full-duplex operation.
module uart_mmio_periph #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    CLKS_PER_BIT = 434,
    parameter logic [DATA_WIDTH-1:0] TX_ADDR      = 32'h1001_0024,
    parameter logic [DATA_WIDTH-1:0] RX_ADDR      = 32'h1001_0028,
    parameter logic [DATA_WIDTH-1:0] CTRL_ADDR    = 32'h1001_002C
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic                  Mem_Write,
    input  logic                  Mem_Read,
    input  logic                  uart_rx,
    output logic                  uart_tx,
    output logic [1:0]            Select,
    output logic [DATA_WIDTH-1:0] Rd_Data
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2) - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Bus decode
    logic wr_tx_s, wr_ctrl_s, rd_rx_s, tx_start_s, clr_err_s, tx_busy_s;

    // Transmitter state
    uart_state_e tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;
    logic [7:0]    tx_data_q, tx_data_d;

    // Receiver state
    logic          rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic          rx_line_s, rx_fall_s, rx_stop_done_s, rx_good_s, rx_bad_s;
    uart_state_e   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          overrun_q, overrun_d;
    logic          framing_q, framing_d;

    logic [DATA_WIDTH-1:0] status_s;
    logic                  unused_wdata_s;

    assign unused_wdata_s = ^Write_Data[DATA_WIDTH-1:8];

    assign wr_tx_s    = Mem_Write && (Address == TX_ADDR);
    assign wr_ctrl_s  = Mem_Write && (Address == CTRL_ADDR);
    assign rd_rx_s    = Mem_Read && (Address == RX_ADDR);
    assign tx_busy_s  = (tx_state_q != ST_IDLE);
    assign tx_start_s = wr_ctrl_s && Write_Data[0] && !tx_busy_s;
    assign clr_err_s  = wr_ctrl_s && Write_Data[1];

    assign rx_line_s      = rx_sync2_q;
    assign rx_fall_s      = rx_prev_q && !rx_line_s;
    assign rx_stop_done_s = (rx_state_q == ST_STOP) && (rx_cnt_q == BIT_LAST);
    assign rx_good_s      = rx_stop_done_s && rx_line_s;
    assign rx_bad_s       = rx_stop_done_s && !rx_line_s;

    assign status_s = {{(DATA_WIDTH-4){1'b0}}, framing_q, overrun_q, rx_valid_q, tx_busy_s};
    assign uart_tx  = tx_line_q;

    // Device select decoded from the address alone
    always_comb begin
        if (Address == TX_ADDR) begin
            Select = 2'b01;
        end else if (Address == RX_ADDR) begin
            Select = 2'b10;
        end else if (Address == CTRL_ADDR) begin
            Select = 2'b11;
        end else begin
            Select = 2'b00;
        end
    end

    // Read-data mux driven by the device select
    always_comb begin
        case (Select)
            2'b01:   Rd_Data = {{(DATA_WIDTH-8){1'b0}}, tx_data_q};
            2'b10:   Rd_Data = {{(DATA_WIDTH-8){1'b0}}, rx_data_q};
            2'b11:   Rd_Data = status_s;
            default: Rd_Data = {DATA_WIDTH{1'b0}};
        endcase
    end

    // TX next state: each bit is held for CLKS_PER_BIT cycles, line updated with the state
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (tx_start_s) begin
                    tx_state_d = ST_START;
                    tx_cnt_d   = CNT_ZERO;
                    tx_bit_d   = 3'd0;
                    tx_shift_d = tx_data_q;
                    tx_line_d  = 1'b0;
                end else begin
                    tx_line_d  = 1'b1;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = CNT_ZERO;
                    tx_line_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d   = tx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = ST_IDLE;
                    tx_cnt_d   = CNT_ZERO;
                    tx_line_d  = 1'b1;
                end else begin
                    tx_cnt_d   = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                tx_cnt_d   = CNT_ZERO;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // RX next state: start rechecked at half a bit, then sampled every bit centre
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_fall_s) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = CNT_ZERO;
                end else begin
                    rx_cnt_d   = CNT_ZERO;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = CNT_ZERO;
                    rx_bit_d = 3'd0;
                    if (rx_line_s) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shift_d = {rx_line_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d   = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d = ST_IDLE;
                    rx_cnt_d   = CNT_ZERO;
                end else begin
                    rx_cnt_d   = rx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                rx_state_d = ST_IDLE;
                rx_cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Data registers and sticky flags; a new byte wins over a coincident read or clear
    always_comb begin
        tx_data_d  = wr_tx_s ? Write_Data[7:0] : tx_data_q;
        rx_data_d  = rx_good_s ? rx_shift_q : rx_data_q;
        rx_valid_d = rx_good_s | (rx_valid_q & ~rd_rx_s);
        overrun_d  = (overrun_q & ~clr_err_s) | (rx_good_s & rx_valid_q & ~rd_rx_s);
        framing_d  = (framing_q & ~clr_err_s) | rx_bad_s;
    end

    // Transmitter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= CNT_ZERO;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_line_q  <= 1'b1;
            tx_data_q  <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Receiver synchronizer, edge detector, FSM and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= CNT_ZERO;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            framing_q  <= 1'b0;
        end else begin
            rx_sync1_q <= uart_rx;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            framing_q  <= framing_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio_periph.sv
// Self-checking bench for uart_mmio_periph with CLKS_PER_BIT = 4.
// Expected TX line bits and RX bytes are queued when stimulus is generated
// and popped when the DUT produces the corresponding output.
module tb_uart_mmio_periph;

    localparam int          DW  = 32;
    localparam int          C   = 4;
    localparam logic [31:0] TXA = 32'h1001_0024;
    localparam logic [31:0] RXA = 32'h1001_0028;
    localparam logic [31:0] CTA = 32'h1001_002C;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] Address;
    logic [DW-1:0] Write_Data;
    logic          Mem_Write;
    logic          Mem_Read;
    logic          uart_rx;
    logic          uart_tx;
    logic [1:0]    Select;
    logic [DW-1:0] Rd_Data;

    int n_checks = 0;
    int n_fail   = 0;

    logic       exp_bits_q[$];
    logic [7:0] exp_rx_q[$];

    always #5 clk = ~clk;

    uart_mmio_periph #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(C),
        .TX_ADDR     (TXA),
        .RX_ADDR     (RXA),
        .CTRL_ADDR   (CTA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Address   (Address),
        .Write_Data(Write_Data),
        .Mem_Write (Mem_Write),
        .Mem_Read  (Mem_Read),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .Select    (Select),
        .Rd_Data   (Rd_Data)
    );

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address    = a;
        Write_Data = d;
        Mem_Write  = 1'b1;
        @(negedge clk);
        Mem_Write  = 1'b0;
    endtask

    task automatic get_status(output logic [31:0] s);
        Address = CTA;
        #1;
        s = Rd_Data;
    endtask

    task automatic rx_read(output logic [31:0] d, output logic [1:0] sel);
        Address  = RXA;
        Mem_Read = 1'b1;
        #1;
        d   = Rd_Data;
        sel = Select;
        @(negedge clk);
        Mem_Read = 1'b0;
        Address  = CTA;
        #1;
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop);
        logic v;
        if (stop) exp_rx_q.push_back(b);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      v = 1'b0;
            else if (k == 9) v = stop;
            else             v = b[k-1];
            for (int c = 0; c < C; c++) begin
                uart_rx = v;
                @(negedge clk);
            end
        end
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Send one TX frame and check every line cycle plus the busy window
    task automatic run_tx_frame(input string name, input logic [7:0] b, input bit inject);
        int   busy_cnt;
        int   vis_cnt;
        logic cur;
        busy_cnt = 0;
        vis_cnt  = 0;
        cur      = 1'b1;
        bus_write(TXA, {24'h0, b});
        bus_write(CTA, 32'h1);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      exp_bits_q.push_back(1'b0);
            else if (k == 9) exp_bits_q.push_back(1'b1);
            else             exp_bits_q.push_back(b[k-1]);
        end
        for (int i = 0; i < 48; i++) begin
            #1;
            if (Select == 2'b11) begin
                if (Rd_Data[0]) busy_cnt++;
                if (i < 40) vis_cnt++;
            end
            if ((i % 4 == 0) && (i < 40)) begin
                if (exp_bits_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s scoreboard empty at cycle %0d: got no entry, need one", name, i);
                end else begin
                    cur = exp_bits_q.pop_front();
                end
            end
            if (i >= 40) cur = 1'b1;
            n_checks++;
            if (uart_tx !== cur) begin
                n_fail++;
                $display("FAIL %s uart_tx cycle %0d: got %b expected %b", name, i, uart_tx, cur);
            end
            if (inject && i == 10) begin
                Address    = TXA;
                Write_Data = 32'h0000_00FF;
                Mem_Write  = 1'b1;
            end else if (inject && i == 11) begin
                Address    = CTA;
                Write_Data = 32'h0000_0001;
            end else if (inject && i == 12) begin
                Mem_Write  = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (busy_cnt != vis_cnt) begin
            n_fail++;
            $display("FAIL %s tx_busy cycles: got %0d expected %0d", name, busy_cnt, vis_cnt);
        end
    endtask

    task automatic test_reset();
        logic [31:0] s;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_uart_tx: got %b expected 1", uart_tx);
        end
        get_status(s);
        n_checks++;
        if (s !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected 00000000", s);
        end
        Address = RXA;
        #1;
        n_checks++;
        if (Rd_Data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rx_data: got %h expected 00000000", Rd_Data);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        Address = CTA;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx();
        run_tx_frame("tx_a5", 8'hA5, 1'b0);
    endtask

    task automatic test_tx_busy_ignore();
        run_tx_frame("tx_busy_restart", 8'h5A, 1'b1);
        Address = TXA;
        #1;
        n_checks++;
        if ((Rd_Data !== 32'h0000_00FF) || (Select !== 2'b01)) begin
            n_fail++;
            $display("FAIL tx_data_reload: got %h sel %b expected 000000ff sel 01", Rd_Data, Select);
        end
    endtask

    task automatic test_rx();
        logic [31:0] s, d;
        logic [1:0]  sel;
        logic [7:0]  e;
        send_serial(8'h3C, 1'b1);
        get_status(s);
        n_checks++;
        if (s !== 32'h2) begin
            n_fail++;
            $display("FAIL rx_valid_status: got %h expected 00000002", s);
        end
        e = exp_rx_q.size() > 0 ? exp_rx_q[$] : 8'h00;
        exp_rx_q.delete();
        rx_read(d, sel);
        n_checks++;
        if ((d !== {24'h0, e}) || (sel !== 2'b10)) begin
            n_fail++;
            $display("FAIL rx_read: got %h sel %b expected %h sel 10", d, sel, {24'h0, e});
        end
        n_checks++;
        if (Rd_Data !== 32'h0) begin
            n_fail++;
            $display("FAIL rx_valid_clear: got status %h expected 00000000", Rd_Data);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] s, d;
        logic [1:0]  sel;
        logic [7:0]  e;
        send_serial(8'h11, 1'b1);
        send_serial(8'h22, 1'b1);
        get_status(s);
        n_checks++;
        if (s !== 32'h6) begin
            n_fail++;
            $display("FAIL overrun_status: got %h expected 00000006", s);
        end
        bus_write(CTA, 32'h2);
        get_status(s);
        n_checks++;
        if (s !== 32'h2) begin
            n_fail++;
            $display("FAIL overrun_clear: got %h expected 00000002", s);
        end
        e = exp_rx_q.size() > 0 ? exp_rx_q[$] : 8'h00;
        exp_rx_q.delete();
        rx_read(d, sel);
        n_checks++;
        if (d !== {24'h0, e}) begin
            n_fail++;
            $display("FAIL overrun_data: got %h expected %h", d, {24'h0, e});
        end
    endtask

    task automatic test_framing();
        logic [31:0] s, d;
        logic [1:0]  sel;
        logic [7:0]  e;
        send_serial(8'h55, 1'b1);
        send_serial(8'h99, 1'b0);
        get_status(s);
        n_checks++;
        if (s !== 32'hA) begin
            n_fail++;
            $display("FAIL framing_status: got %h expected 0000000a", s);
        end
        e = exp_rx_q.size() > 0 ? exp_rx_q[$] : 8'h00;
        exp_rx_q.delete();
        rx_read(d, sel);
        n_checks++;
        if (d !== {24'h0, e}) begin
            n_fail++;
            $display("FAIL framing_data_kept: got %h expected %h", d, {24'h0, e});
        end
        bus_write(CTA, 32'h2);
        get_status(s);
        n_checks++;
        if (s !== 32'h0) begin
            n_fail++;
            $display("FAIL framing_clear: got %h expected 00000000", s);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] s, d;
        logic [1:0]  sel;
        logic [7:0]  e;
        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
        get_status(s);
        n_checks++;
        if (s !== 32'h0) begin
            n_fail++;
            $display("FAIL glitch_no_flags: got %h expected 00000000", s);
        end
        send_serial(8'h81, 1'b1);
        e = exp_rx_q.size() > 0 ? exp_rx_q[$] : 8'h00;
        exp_rx_q.delete();
        rx_read(d, sel);
        n_checks++;
        if (d !== {24'h0, e}) begin
            n_fail++;
            $display("FAIL glitch_then_byte: got %h expected %h", d, {24'h0, e});
        end
    endtask

    task automatic test_select();
        Address = 32'h1001_0000;
        #1;
        n_checks++;
        if ((Select !== 2'b00) || (Rd_Data !== 32'h0)) begin
            n_fail++;
            $display("FAIL select_other: got sel %b data %h expected sel 00 data 00000000", Select, Rd_Data);
        end
        Address = CTA;
        #1;
        n_checks++;
        if (Select !== 2'b11) begin
            n_fail++;
            $display("FAIL select_ctrl: got %b expected 11", Select);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] s;
        bus_write(TXA, 32'h0);
        bus_write(CTA, 32'h1);
        repeat (14) @(negedge clk);
        #1;
        n_checks++;
        if (uart_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_line: got %b expected 0", uart_tx);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_uart_tx: got %b expected 1", uart_tx);
        end
        get_status(s);
        n_checks++;
        if (s !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_status: got %h expected 00000000", s);
        end
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        Address = CTA;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_checks++;
            if ((uart_tx !== 1'b1) || (Rd_Data[0] !== 1'b0)) begin
                n_fail++;
                $display("FAIL post_reset_idle cycle %0d: got tx %b busy %b expected tx 1 busy 0", i, uart_tx, Rd_Data[0]);
            end
            @(negedge clk);
        end
        run_tx_frame("post_reset_c3", 8'hC3, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        Address    = 32'h0;
        Write_Data = 32'h0;
        Mem_Write  = 1'b0;
        Mem_Read   = 1'b0;
        uart_rx    = 1'b1;
        test_reset();
        test_tx();
        test_tx_busy_ignore();
        test_rx();
        test_overrun();
        test_framing();
        test_glitch();
        test_select();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mmio_periph.md
UART_MMIO_PERIPH -- requirements
Module: uart_mmio_periph

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bus data and address width.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit; legal values are >= 4.
REQ-003 SHALL have parameters TX_ADDR, RX_ADDR and CTRL_ADDR, defaults 32'h1001_0024, 32'h1001_0028 and 32'h1001_002C, meaning word addresses of the three registers.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Address, input, DATA_WIDTH: bus address.
REQ-007 SHALL have port Write_Data, input, DATA_WIDTH: bus write data.
REQ-008 SHALL have port Mem_Write, input, 1 bit: write strobe, one cycle per access.
REQ-009 SHALL have port Mem_Read, input, 1 bit: read strobe, one cycle per access.
REQ-010 SHALL have port uart_rx, input, 1 bit: asynchronous serial input, idle high.
REQ-011 SHALL have port uart_tx, output, 1 bit: serial output, idle high.
REQ-012 SHALL have port Select, output, 2 bits: device select for the downstream read-data mux.
REQ-013 SHALL have port Rd_Data, output, DATA_WIDTH: peripheral read data, the mux I_1 input.

Function
REQ-014 SHALL drive Select combinationally from Address alone, independent of the strobes: TX_ADDR gives 2'b01, RX_ADDR gives 2'b10, CTRL_ADDR gives 2'b11, any other address gives 2'b00.
REQ-015 SHALL drive Rd_Data combinationally as follows: Select 01 gives zero-extended tx_data[7:0]; 10 gives zero-extended rx_data[7:0]; 11 gives status; 00 gives 0.
REQ-016 SHALL format status as: bit0 tx_busy, bit1 rx_valid, bit2 overrun, bit3 framing_err, all upper bits 0.
REQ-017 SHALL load tx_data with Write_Data[7:0] on the clk edge where Mem_Write is high and Address equals TX_ADDR; a load while tx_busy SHALL NOT affect the frame in flight.
REQ-018 SHALL start a TX frame on the edge where Mem_Write is high, Address equals CTRL_ADDR, Write_Data[0] is 1 and tx_busy is 0; the same write while tx_busy is 1 SHALL be ignored.
REQ-019 SHALL clear overrun and framing_err on the edge of a write to CTRL_ADDR with Write_Data[1] = 1.
REQ-020 SHALL implement the TX FSM as IDLE -> START -> DATA -> STOP -> IDLE.
REQ-021 SHALL hold each TX bit for exactly CLKS_PER_BIT cycles: start bit 0, then 8 data bits LSB first taken from a shift copy made at start, then one stop bit 1.
REQ-022 SHALL assert tx_busy from the edge after the start write through the last stop-bit cycle, so that a frame occupies 10*CLKS_PER_BIT cycles.
REQ-023 SHALL pass uart_rx through a 2-flop synchronizer before any use.
REQ-024 SHALL implement the RX FSM as IDLE -> START -> DATA -> STOP -> IDLE.
REQ-025 SHALL leave RX IDLE when a synchronized falling edge is seen.
REQ-026 SHALL, in RX START, recheck the line at CLKS_PER_BIT/2 cycles; if it is high (glitch), the FSM SHALL return to IDLE without a flag.
REQ-027 SHALL, in RX DATA, sample 8 bits at bit centres, CLKS_PER_BIT apart, LSB first.
REQ-028 SHALL, in RX STOP, sample at the bit centre; if the sample is 1, rx_data SHALL be loaded and rx_valid set on that edge.
REQ-029 SHALL, if the RX stop sample is 0, set framing_err and leave rx_data and rx_valid unchanged.
REQ-030 SHALL, when a good byte completes while rx_valid is already 1, overwrite rx_data and set overrun.
REQ-031 SHALL clear rx_valid on the edge where Mem_Read is high and Address equals RX_ADDR.
REQ-032 SHALL, when that read coincides with a good byte completing, leave rx_valid at 1, load the new byte and NOT set overrun.
REQ-033 SHALL run the TX and RX FSMs independently, so that full duplex is supported.

Reset
REQ-034 SHALL, while rst_n is low, immediately force uart_tx=1, tx_data=0, rx_data=0, all status flags 0, both FSMs to IDLE, all bit/baud counters to 0 and both synchronizer flops to 1.
REQ-035 SHALL abort any frame in progress when reset is asserted mid-frame; after release, TX SHALL stay idle-high and RX SHALL wait for a new falling edge.

Verification (CLKS_PER_BIT=4)
REQ-036 Bench SHALL cover: write TX_ADDR=0xA5, then write CTRL=0x1 -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1, 4 cycles each; tx_busy high for 40 cycles.
REQ-037 Bench SHALL cover: drive serial 0x3C with a good stop bit -> rx_valid=1; read RX_ADDR -> Rd_Data=0x3C, Select=2'b10, rx_valid=0 on the next cycle.
REQ-038 Bench SHALL cover: send two bytes 0x11 then 0x22 without a read -> rx_data=0x22, overrun=1; write CTRL=0x2 -> status=0x2.
REQ-039 Bench SHALL cover: frame with stop bit 0 -> framing_err=1, rx_valid unchanged; a 1-cycle low glitch -> no flags, RX returns to IDLE.
REQ-040 Bench SHALL cover: write CTRL=0x1 while tx_busy -> frame unchanged, no restart; Address=0x1001_0000 -> Select=2'b00, Rd_Data=0.
REQ-041 Bench SHALL cover: assert rst_n low mid-TX frame -> uart_tx=1 immediately, status=0, and a new frame works after release.
